data_mem_sys: RTL and testbench



---
 rtl/mem_map_pkg.sv | 42 ++++
 rtl/tx_fifo.sv | 53 +++++
 rtl/data_mem_sys.sv | 134 +++++++++++++
 tb/tb_data_mem_sys.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map, register bit positions and decode helper for data_mem_sys
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR     = 32'h1000_0000;
    localparam logic [31:0] TX_ADDR      = 32'h1000_0004;
    localparam logic [31:0] TMR_CNT_ADDR = 32'h1000_0008;
    localparam logic [31:0] TMR_CMP_ADDR = 32'h1000_000C;
    localparam logic [31:0] CTRL_ADDR    = 32'h1000_0010;

    localparam int CTRL_PEND_BIT = 0;
    localparam int CTRL_EN_BIT   = 1;
    localparam int CTRL_OVF_BIT  = 2;

    localparam int TX_CNT_W     = 8;
    localparam int TX_FULL_BIT  = 8;
    localparam int TX_OVF_BIT   = 9;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_TX,
        SEL_CNT,
        SEL_CMP,
        SEL_CTRL
    } sel_e;

    // Byte-lane bits are dropped before matching: only word accesses exist.
    function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if ((a - RAM_BASE) < ram_bytes) return SEL_RAM;
        else if (a == LED_ADDR)         return SEL_LED;
        else if (a == TX_ADDR)          return SEL_TX;
        else if (a == TMR_CNT_ADDR)     return SEL_CNT;
        else if (a == TMR_CMP_ADDR)     return SEL_CMP;
        else if (a == CTRL_ADDR)        return SEL_CTRL;
        else                            return SEL_NONE;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte FIFO with simultaneous push/pop support when full
module tx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic [7:0]    head_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign count_o = cnt_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

endmodule

// File: rtl/data_mem_sys.sv
// rtl/data_mem_sys.sv - data RAM plus LED, TX FIFO and timer I/O page on the CPU data port
module data_mem_sys
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [7:0]  led_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);

    localparam int          RW        = $clog2(RAM_WORDS);
    localparam int          FAW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]         ram_q [RAM_WORDS];
    logic [RW-1:0]       ram_idx;
    sel_e                sel;
    logic                store;

    logic [7:0]          led_q, led_d;
    logic [31:0]         cnt_q, cnt_d, cmp_q, cmp_d;
    logic                en_q, en_d, pend_q, pend_d, ovf_q, ovf_d;

    logic                tx_push, tx_pop, fifo_full, fifo_empty;
    logic [FAW:0]        fifo_cnt;
    logic [TX_CNT_W-1:0] cnt8;

    assign sel     = decode(addr_i, RAM_BYTES);
    assign store   = ce_i & we_i;
    assign ram_idx = addr_i[RW+1:2];
    assign tx_push = store & (sel == SEL_TX);
    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign cnt8    = TX_CNT_W'(fifo_cnt);

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .data_i  (wdata_i[7:0]),
        .pop_i   (tx_ready_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt),
        .head_o  (tx_data_o)
    );

    assign tx_valid_o = ~fifo_empty;

    // Stores landing on the reset edge are discarded, RAM included.
    always_ff @(posedge clk) begin
        if (rst && store && sel == SEL_RAM) ram_q[ram_idx] <= wdata_i;
    end

    always_comb begin
        led_d  = led_q;
        cmp_d  = cmp_q;
        en_d   = en_q;
        cnt_d  = cnt_q + 32'd1;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (store) begin
            case (sel)
                SEL_LED: led_d = wdata_i[7:0];
                SEL_CNT: cnt_d = wdata_i;
                SEL_CMP: cmp_d = wdata_i;
                SEL_CTRL: begin
                    en_d = wdata_i[CTRL_EN_BIT];
                    if (wdata_i[CTRL_PEND_BIT]) pend_d = 1'b0;
                    if (wdata_i[CTRL_OVF_BIT])  ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end
        // Sets are applied after clears so a colliding set wins.
        if (en_q && cnt_q == cmp_q)                pend_d = 1'b1;
        if (tx_push && fifo_full && !tx_pop)       ovf_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q  <= '0;
            cnt_q  <= '0;
            cmp_q  <= '1;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (ce_i && !we_i) begin
            case (sel)
                SEL_RAM:  rdata_o = ram_q[ram_idx];
                SEL_LED:  rdata_o[7:0] = led_q;
                SEL_TX: begin
                    rdata_o[TX_CNT_W-1:0] = cnt8;
                    rdata_o[TX_FULL_BIT]  = fifo_full;
                    rdata_o[TX_OVF_BIT]   = ovf_q;
                end
                SEL_CNT:  rdata_o = cnt_q;
                SEL_CMP:  rdata_o = cmp_q;
                SEL_CTRL: begin
                    rdata_o[CTRL_PEND_BIT] = pend_q;
                    rdata_o[CTRL_EN_BIT]   = en_q;
                    rdata_o[CTRL_OVF_BIT]  = ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign led_o = led_q;
    assign irq_o = pend_q;

endmodule

// File: tb/tb_data_mem_sys.sv
// tb/tb_data_mem_sys.sv - scoreboard bench for data_mem_sys
module tb_data_mem_sys;

    localparam logic [31:0] A_LED  = 32'h1000_0000;
    localparam logic [31:0] A_TX   = 32'h1000_0004;
    localparam logic [31:0] A_CNT  = 32'h1000_0008;
    localparam logic [31:0] A_CMP  = 32'h1000_000C;
    localparam logic [31:0] A_CTRL = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0, we = 1'b0, tx_ready = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  led, tx_data;
    logic        tx_valid, irq;

    int total = 0;
    int bad = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] ram_addr_q[$];
    logic [31:0] ram_data_q[$];

    always #5 clk = ~clk;

    data_mem_sys #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .led_o(led), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready), .irq_o(irq)
    );

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        ce = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        do_write(A_TX, {24'h0, b});
        if (exp_q.size() < 8) exp_q.push_back(b);
    endtask

    task automatic drain_fifo(input string tag);
        int guard;
        logic [7:0] want;
        guard = 0;
        @(negedge clk);
        tx_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 20) begin
            #1;
            want = exp_q.pop_front();
            total++;
            if (tx_valid !== 1'b1 || tx_data !== want) begin
                bad++;
                $display("FAIL %s_drain: valid=%b data=%h want valid=1 data=%h", tag, tx_valid, tx_data, want);
            end
            guard++;
            @(negedge clk);
        end
        #1;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_empty: valid=%b want 0", tag, tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({led, tx_valid, tx_data, irq} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: led=%h valid=%b data=%h irq=%b want all 0", led, tx_valid, tx_data, irq);
        end
        do_read(A_CMP, d);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp: got %h want ffffffff", d); end
        do_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
        do_read(A_TX, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_tx_status: got %h want 0", d); end
    endtask

    task automatic test_ram;
        logic [31:0] d, a, w;
        logic [31:0] addrs[4];
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h24; addrs[3] = 32'hFFC;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            do_write(addrs[i], w);
            ram_addr_q.push_back(addrs[i]);
            ram_data_q.push_back(w);
        end
        while (ram_addr_q.size() > 0) begin
            a = ram_addr_q.pop_front();
            w = ram_data_q.pop_front();
            do_read(a, d);
            total++;
            if (d !== w) begin bad++; $display("FAIL ram_read@%h: got %h want %h", a, d, w); end
        end
        do_read(32'h13, d);
        total++;
        if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_unaligned: got %h want deadbeef", d); end
        do_read(32'h2000_0000, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want 0", d); end
        do_read(32'h1000, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL past_ram_read: got %h want 0", d); end
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = 32'h10;
        #1;
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL read_ce_low: got %h want 0", rdata); end
        ce = 1'b1; we = 1'b1; wdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL read_during_store: got %h want 0", rdata); end
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic test_led;
        logic [31:0] d;
        do_write(A_LED, 32'hA5);
        do_read(A_LED, d);
        total++;
        if (led !== 8'hA5 || d !== 32'hA5) begin bad++; $display("FAIL led_a5: led=%h rd=%h want a5", led, d); end
        do_write(A_LED, 32'h1FF);
        total++;
        if (led !== 8'hFF) begin bad++; $display("FAIL led_trunc: led=%h want ff", led); end
    endtask

    task automatic test_fifo_overflow;
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i));
        do_read(A_TX, d);
        total++;
        if (d !== 32'h308) begin bad++; $display("FAIL ovf_status: got %h want 308", d); end
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            bad++; $display("FAIL ovf_head_hold: valid=%b data=%h want 1/41", tx_valid, tx_data);
        end
        do_read(A_CTRL, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL ovf_ctrl: got %h want 4", d); end
        drain_fifo("ovf");
        do_write(A_CTRL, 32'h4);
        do_read(A_TX, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ovf_clear: got %h want 0", d); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] d;
        logic [7:0]  want;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i));
        do_read(A_TX, d);
        total++;
        if (d !== 32'h108) begin bad++; $display("FAIL full_status: got %h want 108", d); end
        @(negedge clk);
        tx_ready = 1'b1; ce = 1'b1; we = 1'b1; addr = A_TX; wdata = 32'h5A;
        #1;
        want = exp_q.pop_front();
        exp_q.push_back(8'h5A);
        total++;
        if (tx_data !== want) begin bad++; $display("FAIL pushpop_head: got %h want %h", tx_data, want); end
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0; tx_ready = 1'b0;
        do_read(A_TX, d);
        total++;
        if (d !== 32'h108) begin bad++; $display("FAIL pushpop_status: got %h want 108", d); end
        drain_fifo("pushpop");
    endtask

    task automatic test_timer_irq;
        logic [31:0] d;
        do_write(A_CMP, 32'd20);
        do_write(A_CNT, 32'd1000);
        do_write(A_CTRL, 32'h2);
        do_write(A_CNT, 32'd0);
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (irq !== (k == 21)) begin bad++; $display("FAIL irq_edge k=%0d: irq=%b want %b", k, irq, (k == 21)); end
            if (k == 20) begin
                ce = 1'b1; we = 1'b0; addr = A_CNT;
                #1;
                total++;
                if (rdata !== 32'd20) begin bad++; $display("FAIL irq_count: got %0d want 20", rdata); end
                ce = 1'b0;
            end
        end
        do_write(A_CNT, 32'd18);
        repeat (2) @(posedge clk);
        do_write(A_CTRL, 32'h3);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: irq=%b want 1", irq); end
        do_write(A_CTRL, 32'h3);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: irq=%b want 0", irq); end
        do_read(A_CTRL, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL irq_ctrl: got %h want 2", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'h71 + 8'(i));
        do_write(A_LED, 32'h3C);
        do_write(A_CMP, 32'd495);
        do_write(A_CNT, 32'd490);
        repeat (10) @(posedge clk);
        do_read(A_CNT, d);
        total++;
        if (d !== 32'd500 || irq !== 1'b1 || tx_valid !== 1'b1) begin
            bad++; $display("FAIL mid_pre: cnt=%0d irq=%b valid=%b want 500/1/1", d, irq, tx_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        ce = 1'b1; we = 1'b0; addr = A_CNT;
        #1;
        total++;
        if (rdata !== 32'h0 || tx_valid !== 1'b0 || led !== 8'h0 || irq !== 1'b0) begin
            bad++; $display("FAIL mid_post: cnt=%h valid=%b led=%h irq=%b want all 0", rdata, tx_valid, led, irq);
        end
        ce = 1'b0;
        do_read(A_TX, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mid_tx_status: got %h want 0", d); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_led;
        test_fifo_overflow;
        test_full_push_pop;
        test_timer_irq;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
        $fatal(1);
    end

endmodule
